// File: rtl/ahb_uart_lite_if.sv
// ahb_uart_lite_if: AHB-Lite slave bundle for the UART on matrix port M2
//   master: drives HSEL, HREADY, HTRANS, HSIZE, HWRITE, HADDR, HWDATA
//   slave : returns HREADYOUT, HRESP, HRDATA
`timescale 1ns/1ps
interface ahb_uart_lite_if;
    logic        HSEL;
    logic        HREADY;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [11:0] HADDR;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    modport master (
        output HSEL, HREADY, HTRANS, HSIZE, HWRITE, HADDR, HWDATA,
        input  HREADYOUT, HRESP, HRDATA
    );
    modport slave (
        input  HSEL, HREADY, HTRANS, HSIZE, HWRITE, HADDR, HWDATA,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_uart_lite.sv
// ahb_uart_lite: AHB-Lite 8N1 UART with TX FIFO, RX holding register, baud divider and level IRQ
//   sysclk/RSTn : clock, async active-low reset
//   bus         : AHB-Lite slave (zero wait states, always OKAY)
//   RXD         : async serial input, TXD : serial output (idle high)
//   IRQ         : registered level interrupt
`timescale 1ns/1ps
module ahb_uart_lite #(
    parameter int          TXDEPTH  = 4,
    parameter logic [15:0] BAUD_RST = 16'd234
) (
    input  logic           sysclk,
    input  logic           RSTn,
    ahb_uart_lite_if.slave bus,
    input  logic           RXD,
    output logic           TXD,
    output logic           IRQ
);
    localparam int PW = $clog2(TXDEPTH);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    logic        acc_wr, acc_rd;
    logic [9:0]  acc_addr;
    logic        wr_data, wr_status, wr_ctrl, wr_baud, rd_data;
    logic [3:0]  ctrl;
    logic [15:0] bauddiv;
    logic [7:0]  rxbuf;
    logic        rxvalid, rxovr, ferr, txovr;
    logic [PW:0] wptr, rptr;
    logic [7:0]  fifo [TXDEPTH];
    logic        full, empty, push, pop, txempty;
    state_t      tx_state, tx_next, rx_state, rx_next;
    logic [15:0] tx_cnt, rx_cnt;
    logic [2:0]  tx_bit, rx_bit;
    logic [7:0]  tx_sh, rx_sh;
    logic        tx_tick, rx_tick;
    logic        rx_s1, rx_s2, rx_prev, rx_fall, rx_done, rx_take, rx_ovr;
    logic        unused_ok;
    assign bus.HREADYOUT = 1'b1;
    assign bus.HRESP     = 1'b0;
    assign unused_ok     = &{1'b0, bus.HSIZE, bus.HTRANS[0], bus.HADDR[1:0], bus.HWDATA[31:16]};
    // Address phase capture; our data phase always completes in one cycle
    always_ff @(posedge sysclk or negedge RSTn)
        if (!RSTn) begin
            acc_wr   <= 1'b0;
            acc_rd   <= 1'b0;
            acc_addr <= '0;
        end else if (bus.HREADY) begin
            acc_wr   <= bus.HSEL & bus.HTRANS[1] & bus.HWRITE;
            acc_rd   <= bus.HSEL & bus.HTRANS[1] & ~bus.HWRITE;
            acc_addr <= bus.HADDR[11:2];
        end
    assign wr_data   = acc_wr && acc_addr == 10'd0;
    assign wr_status = acc_wr && acc_addr == 10'd1;
    assign wr_ctrl   = acc_wr && acc_addr == 10'd2;
    assign wr_baud   = acc_wr && acc_addr == 10'd3;
    assign rd_data   = acc_rd && acc_addr == 10'd0;
    assign bus.HRDATA = !acc_rd             ? 32'd0 :
                        acc_addr == 10'd0   ? {24'd0, rxbuf} :
                        acc_addr == 10'd1   ? {26'd0, txovr, ferr, rxovr, rxvalid, txempty, full} :
                        acc_addr == 10'd2   ? {28'd0, ctrl} :
                        acc_addr == 10'd3   ? {16'd0, bauddiv} : 32'd0;
    // Status flags: hardware set has priority over the W1C clear
    always_ff @(posedge sysclk or negedge RSTn)
        if (!RSTn) begin
            ctrl    <= '0;
            bauddiv <= BAUD_RST;
            rxbuf   <= '0;
            rxvalid <= 1'b0;
            rxovr   <= 1'b0;
            ferr    <= 1'b0;
            txovr   <= 1'b0;
            IRQ     <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl <= bus.HWDATA[3:0];
            if (wr_baud) bauddiv <= bus.HWDATA[15:0] < 16'd15 ? 16'd15 : bus.HWDATA[15:0];
            if (rx_take) rxbuf <= rx_sh;
            rxvalid <= rx_take ? 1'b1 : rd_data ? 1'b0 : rxvalid;
            rxovr   <= rx_ovr | (rxovr & ~(wr_status & bus.HWDATA[3]));
            ferr    <= (rx_done & ~rx_s2) | (ferr & ~(wr_status & bus.HWDATA[4]));
            txovr   <= (wr_data & full & ~pop) | (txovr & ~(wr_status & bus.HWDATA[5]));
            IRQ     <= (ctrl[2] & txempty) | (ctrl[3] & rxvalid);
        end
    // TX FIFO: extra pointer MSB distinguishes full from empty
    assign empty   = wptr == rptr;
    assign full    = wptr == {~rptr[PW], rptr[PW-1:0]};
    assign push    = wr_data & (~full | pop);
    assign txempty = empty && tx_state == IDLE;
    always_ff @(posedge sysclk or negedge RSTn)
        if (!RSTn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + (PW+1)'(1);
            if (pop) rptr <= rptr + (PW+1)'(1);
        end
    always_ff @(posedge sysclk)
        if (push) fifo[wptr[PW-1:0]] <= bus.HWDATA[7:0];
    // TX FSM
    assign tx_tick = tx_cnt == 16'd0;
    always_ff @(posedge sysclk or negedge RSTn)
        if (!RSTn) tx_state <= IDLE;
        else tx_state <= tx_next;
    always_comb begin
        tx_next = tx_state;
        pop     = 1'b0;
        case (tx_state)
            IDLE:  if (ctrl[0] & ~empty) begin
                       pop     = 1'b1;
                       tx_next = START;
                   end
            START: if (tx_tick) tx_next = DATA;
            DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = STOP;
            STOP:  if (tx_tick) begin
                       pop     = ctrl[0] & ~empty;
                       tx_next = pop ? START : IDLE;
                   end
            default: tx_next = IDLE;
        endcase
    end
    // Counter reloads from bauddiv at every bit boundary, so divider changes land there
    always_ff @(posedge sysclk or negedge RSTn)
        if (!RSTn) begin
            tx_cnt <= BAUD_RST;
            tx_bit <= '0;
            tx_sh  <= '0;
        end else begin
            tx_cnt <= (tx_state == IDLE || tx_tick) ? bauddiv : tx_cnt - 16'd1;
            tx_bit <= tx_state != DATA ? 3'd0 : tx_tick ? tx_bit + 3'd1 : tx_bit;
            tx_sh  <= pop ? fifo[rptr[PW-1:0]] : (tx_state == DATA && tx_tick) ? {1'b0, tx_sh[7:1]} : tx_sh;
        end
    assign TXD = tx_state == START ? 1'b0 : tx_state == DATA ? tx_sh[0] : 1'b1;
    // RX synchronizer and falling-edge detect
    always_ff @(posedge sysclk or negedge RSTn)
        if (!RSTn) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= RXD;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    assign rx_fall = rx_prev & ~rx_s2;
    assign rx_tick = rx_cnt == 16'd0;
    assign rx_done = rx_state == STOP && rx_tick && ctrl[1];
    // A DATA read in the same cycle frees the holding register for the new byte
    assign rx_take = rx_done & rx_s2 & (~rxvalid | rd_data);
    assign rx_ovr  = rx_done & rx_s2 & rxvalid & ~rd_data;
    always_ff @(posedge sysclk or negedge RSTn)
        if (!RSTn) rx_state <= IDLE;
        else rx_state <= rx_next;
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            IDLE:  if (rx_fall) rx_next = START;
            START: if (rx_tick) rx_next = rx_s2 ? IDLE : DATA;
            DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = STOP;
            STOP:  if (rx_tick) rx_next = IDLE;
            default: rx_next = IDLE;
        endcase
        if (!ctrl[1]) rx_next = IDLE;
    end
    // IDLE preloads the half-bit delay so START samples mid start bit
    always_ff @(posedge sysclk or negedge RSTn)
        if (!RSTn) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_sh  <= '0;
        end else begin
            rx_cnt <= rx_state == IDLE ? (bauddiv - 16'd1) >> 1 : rx_tick ? bauddiv : rx_cnt - 16'd1;
            rx_bit <= rx_state != DATA ? 3'd0 : rx_tick ? rx_bit + 3'd1 : rx_bit;
            rx_sh  <= (rx_state == DATA && rx_tick) ? {rx_s2, rx_sh[7:1]} : rx_sh;
        end
endmodule
